// File: rtl/poly_addsub_engine.sv
// rtl/poly_addsub_engine.sv - streaming modular add/subtract/copy over two coefficient RAMs
// Reads M words of LANES coefficients, writes (a op b) mod Q one cycle after the data arrives.
module poly_addsub_engine #(
   parameter int WIDTH = 12,
   parameter int Q     = 3329,
   parameter int LANES = 2,
   parameter int DEPTH = 256,
   localparam int M    = DEPTH / LANES,
   localparam int AW   = (M > 1) ? $clog2(M) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic [1:0]               mode,
   output logic                     rd_en,
   output logic [AW-1:0]            rd_addr,
   input  logic [LANES*WIDTH-1:0]   a_data,
   input  logic [LANES*WIDTH-1:0]   b_data,
   output logic                     wr_en,
   output logic [AW-1:0]            wr_addr,
   output logic [LANES*WIDTH-1:0]   wr_data,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [WIDTH:0] QW = (WIDTH + 1)'(Q);

   state_t                    r_state;
   logic [1:0]                r_mode;
   logic                      r_data_vld;
   logic [AW-1:0]             r_data_addr;
   logic                      r_drain;
   logic [LANES*WIDTH-1:0]    w_res;
   logic [LANES-1:0]          w_bad;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [WIDTH-1:0] w_a, w_b, w_x, w_y;
      logic [WIDTH:0]   w_sum, w_diff, w_sum_c, w_diff_c;

      assign w_a      = a_data[g*WIDTH +: WIDTH];
      assign w_b      = b_data[g*WIDTH +: WIDTH];
      assign w_x      = (r_mode == 2'b10) ? w_b : w_a;
      assign w_y      = (r_mode == 2'b10) ? w_a : w_b;
      assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
      // Bias by Q so the difference never goes negative for in-range operands.
      assign w_diff   = {1'b0, w_x} - {1'b0, w_y} + QW;
      assign w_sum_c  = (w_sum >= QW) ? w_sum - QW : w_sum;
      assign w_diff_c = (w_diff >= QW) ? w_diff - QW : w_diff;

      assign w_res[g*WIDTH +: WIDTH] = (r_mode == 2'b11) ? w_a :
                                       (r_mode == 2'b00) ? w_sum_c[WIDTH-1:0] :
                                                           w_diff_c[WIDTH-1:0];
      assign w_bad[g] = ({1'b0, w_a} >= QW) ||
                        ((r_mode != 2'b11) && ({1'b0, w_b} >= QW));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mode      <= 2'b00;
         r_data_vld  <= 1'b0;
         r_data_addr <= '0;
         r_drain     <= 1'b0;
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done        <= 1'b0;
         r_data_vld  <= rd_en;
         r_data_addr <= rd_addr;
         wr_en       <= r_data_vld;
         if (r_data_vld) begin
            wr_addr <= r_data_addr;
            wr_data <= w_res;
            if (|w_bad)
               err <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_state <= S_READ;
                  r_mode  <= mode;
                  rd_en   <= 1'b1;
                  rd_addr <= '0;
                  busy    <= 1'b1;
                  err     <= 1'b0;
               end
            end
            S_READ: begin
               if (rd_addr == AW'(M - 1)) begin
                  rd_en   <= 1'b0;
                  r_drain <= 1'b0;
                  r_state <= S_DRAIN;
               end else begin
                  rd_addr <= rd_addr + AW'(1);
               end
            end
            S_DRAIN: begin
               if (r_drain) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end else begin
                  r_drain <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_addsub_engine.sv
// tb/tb_poly_addsub_engine.sv - scoreboard bench for poly_addsub_engine
// Cycle index n counts samples taken at the negedge after the run-accepting edge.
module tb_poly_addsub_engine;

   localparam int WIDTH = 12;
   localparam int Q     = 3329;
   localparam int LANES = 2;
   localparam int DEPTH = 8;
   localparam int M     = 4;
   localparam int AW    = 2;
   localparam int DW    = LANES * WIDTH;

   logic          clk = 1'b0;
   logic          rst, run;
   logic [1:0]    mode;
   logic          rd_en, wr_en, busy, done, err;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] a_data, b_data, wr_data;

   always #5 clk = ~clk;

   poly_addsub_engine #(.WIDTH(WIDTH), .Q(Q), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .run(run), .mode(mode),
      .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err)
   );

   logic [DW-1:0] a_mem [M];
   logic [DW-1:0] b_mem [M];

   initial begin
      a_data = '0;
      b_data = '0;
   end

   always @(posedge clk) begin
      if (rd_en) begin
         a_data <= a_mem[rd_addr];
         b_data <= b_mem[rd_addr];
      end
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            n;
   } wr_t;

   wr_t           exp_q[$];
   wr_t           obs_q[$];
   logic          o_busy [32];
   logic          o_done [32];
   logic          o_err  [32];
   logic          o_rd   [32];
   logic [AW-1:0] o_rdaddr [32];
   int            total = 0;
   int            bad = 0;

   function automatic int lane_model(input logic [1:0] md, input int a, input int b);
      case (md)
         2'b00:   return (a + b) % Q;
         2'b01:   return (a - b + Q) % Q;
         2'b10:   return (b - a + Q) % Q;
         default: return a;
      endcase
   endfunction

   function automatic logic [DW-1:0] word_model(input logic [1:0] md,
                                                input logic [DW-1:0] aw,
                                                input logic [DW-1:0] bw);
      logic [DW-1:0] r;
      int            t;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         t = lane_model(md, int'(aw[l*WIDTH +: WIDTH]), int'(bw[l*WIDTH +: WIDTH]));
         r[l*WIDTH +: WIDTH] = t[WIDTH-1:0];
      end
      return r;
   endfunction

   task automatic set_word(input int w, input int a0, input int a1, input int b0, input int b1);
      a_mem[w] = {WIDTH'(a1), WIDTH'(a0)};
      b_mem[w] = {WIDTH'(b1), WIDTH'(b0)};
   endtask

   task automatic expect_all(input logic [1:0] md);
      exp_q.delete();
      for (int w = 0; w < M; w++)
         exp_q.push_back('{AW'(w), word_model(md, a_mem[w], b_mem[w]), w + 2});
   endtask

   task automatic collect(input logic [1:0] md, input int run_cycles, input int ncyc);
      obs_q.delete();
      @(negedge clk);
      mode = md;
      run  = 1'b1;
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk);
         #1;
         if (n == run_cycles - 1) begin
            run  = 1'b0;
            mode = ~md;
         end
         @(negedge clk);
         o_busy[n]   = busy;
         o_done[n]   = done;
         o_err[n]    = err;
         o_rd[n]     = rd_en;
         o_rdaddr[n] = rd_addr;
         if (wr_en)
            obs_q.push_back('{wr_addr, wr_data, n});
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      run  = 1'b0;
      mode = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({rd_en, wr_en, busy, done, err} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b expected 00000", {rd_en, wr_en, busy, done, err});
      end
      total++;
      if ({rd_addr, wr_addr, wr_data} !== '0) begin
         bad++;
         $display("FAIL reset_buses: got rd_addr=%0d wr_addr=%0d wr_data=%h expected 0",
                  rd_addr, wr_addr, wr_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      wr_t e, o;
      int  dn = -1, dc = 0;
      set_word(0, 3328, 3328, 1, 1);
      set_word(1, 3328, 3328, 1, 1);
      set_word(2, 1000, 1000, 2000, 2000);
      set_word(3, 1000, 1000, 2000, 2000);
      expect_all(2'b00);
      collect(2'b00, 1, 10);
      for (int n = 0; n <= M; n++) begin
         total++;
         if (o_rd[n] !== (n < M) || (n < M && o_rdaddr[n] !== AW'(n))) begin
            bad++;
            $display("FAIL add_read n=%0d: got rd_en=%b rd_addr=%0d expected rd_en=%b rd_addr=%0d",
                     n, o_rd[n], o_rdaddr[n], (n < M), n);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL add_word: got no write expected addr=%0d data=%h", e.addr, e.data);
         end else begin
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.data !== e.data || o.n != e.n) begin
               bad++;
               $display("FAIL add_word: got addr=%0d data=%h n=%0d expected addr=%0d data=%h n=%0d",
                        o.addr, o.data, o.n, e.addr, e.data, e.n);
            end
         end
      end
      for (int n = 0; n < 10; n++)
         if (o_done[n] === 1'b1) begin dc++; dn = n; end
      total++;
      if (dc != 1 || dn != 6) begin
         bad++;
         $display("FAIL add_done: got %0d pulses at n=%0d expected 1 pulse at n=6", dc, dn);
      end
      total++;
      if (o_err[9] !== 1'b0) begin
         bad++;
         $display("FAIL add_err: got %b expected 0", o_err[9]);
      end
   endtask

   task automatic test_sub();
      wr_t e, o;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            set_word(0, 0, 0, 3328, 3328);
            set_word(1, 0, 0, 3328, 3328);
            set_word(2, 5, 5, 5, 5);
            set_word(3, 5, 5, 5, 5);
            expect_all(2'b01);
            collect(2'b01, 1, 10);
         end else begin
            for (int w = 0; w < M; w++) set_word(w, 3328, 3328, 0, 0);
            expect_all(2'b10);
            collect(2'b10, 1, 10);
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
               bad++;
               $display("FAIL sub_word pass=%0d: got no write expected addr=%0d", pass, e.addr);
            end else begin
               o = obs_q.pop_front();
               if (o.addr !== e.addr || o.data !== e.data || o.n != e.n) begin
                  bad++;
                  $display("FAIL sub_word pass=%0d: got addr=%0d data=%h n=%0d expected addr=%0d data=%h n=%0d",
                           pass, o.addr, o.data, o.n, e.addr, e.data, e.n);
               end
            end
         end
         total++;
         if (o_err[9] !== 1'b0 || o_done[6] !== 1'b1) begin
            bad++;
            $display("FAIL sub_status pass=%0d: got err=%b done6=%b expected err=0 done6=1",
                     pass, o_err[9], o_done[6]);
         end
      end
   endtask

   task automatic test_err();
      for (int w = 0; w < M; w++) set_word(w, 0, 0, 0, 0);
      set_word(2, 0, 0, 0, 4095);
      collect(2'b01, 1, 10);
      total++;
      if (o_err[3] !== 1'b0) begin
         bad++;
         $display("FAIL err_early: got %b expected 0", o_err[3]);
      end
      total++;
      if (o_err[4] !== 1'b1) begin
         bad++;
         $display("FAIL err_set: got %b expected 1", o_err[4]);
      end
      total++;
      if (o_err[9] !== 1'b1 || o_done[6] !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky: got err=%b done6=%b expected err=1 done6=1", o_err[9], o_done[6]);
      end
      set_word(2, 0, 0, 0, 0);
      collect(2'b01, 1, 8);
      total++;
      if (o_err[0] !== 1'b0 || o_err[7] !== 1'b0) begin
         bad++;
         $display("FAIL err_clear: got n0=%b n7=%b expected 0", o_err[0], o_err[7]);
      end
   endtask

   task automatic test_back_to_back();
      int nwr;
      logic exp_busy, exp_done;
      for (int w = 0; w < M; w++) set_word(w, 7, 8, 9, 10);
      collect(2'b00, 20, 28);
      for (int n = 0; n < 28; n++) begin
         exp_busy = (n <= 22) && (n % 8 != 7);
         exp_done = (n <= 22) && (n % 8 == 6);
         total++;
         if (o_busy[n] !== exp_busy || o_done[n] !== exp_done) begin
            bad++;
            $display("FAIL b2b n=%0d: got busy=%b done=%b expected busy=%b done=%b",
                     n, o_busy[n], o_done[n], exp_busy, exp_done);
         end
      end
      nwr = obs_q.size();
      total++;
      if (nwr != 3 * M) begin
         bad++;
         $display("FAIL b2b_writes: got %0d expected %0d", nwr, 3 * M);
      end
   endtask

   task automatic test_mid_reset();
      wr_t e, o;
      int  seen = 0;
      for (int w = 0; w < M; w++) set_word(w, 100 + w, 200 + w, 3000, 3100);
      @(negedge clk);
      mode = 2'b00;
      run  = 1'b1;
      @(posedge clk);
      #1 run = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++;
      if ({rd_en, wr_en, busy, done, err, rd_addr, wr_addr, wr_data} !== '0) begin
         bad++;
         $display("FAIL midrst_outputs: got rd_en=%b wr_en=%b busy=%b done=%b err=%b rd_addr=%0d wr_addr=%0d wr_data=%h expected 0",
                  rd_en, wr_en, busy, done, err, rd_addr, wr_addr, wr_data);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (wr_en || done || busy) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL midrst_quiet: got %0d active cycles expected 0", seen);
      end
      expect_all(2'b00);
      collect(2'b00, 1, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL midrst_word: got no write expected addr=%0d", e.addr);
         end else begin
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.data !== e.data || o.n != e.n) begin
               bad++;
               $display("FAIL midrst_word: got addr=%0d data=%h n=%0d expected addr=%0d data=%h n=%0d",
                        o.addr, o.data, o.n, e.addr, e.data, e.n);
            end
         end
      end
      total++;
      if (o_done[6] !== 1'b1) begin
         bad++;
         $display("FAIL midrst_done: got %b expected 1", o_done[6]);
      end
   endtask

   task automatic test_copy();
      wr_t e, o;
      for (int w = 0; w < M; w++)
         set_word(w, $urandom_range(Q - 1), $urandom_range(Q - 1),
                  $urandom_range(4095), $urandom_range(4095));
      expect_all(2'b11);
      collect(2'b11, 1, 10);
      for (int w = 0; w < M; w++) begin
         e = exp_q.pop_front();
         total++;
         if (e.data !== a_mem[w] || obs_q.size() == 0) begin
            bad++;
            $display("FAIL copy_word w=%0d: got %0d writes left expected data=%h", w, obs_q.size(), a_mem[w]);
         end else begin
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.data !== e.data || o.n != e.n) begin
               bad++;
               $display("FAIL copy_word: got addr=%0d data=%h n=%0d expected addr=%0d data=%h n=%0d",
                        o.addr, o.data, o.n, e.addr, e.data, e.n);
            end
         end
      end
      total++;
      if (o_err[9] !== 1'b0) begin
         bad++;
         $display("FAIL copy_err: got %b expected 0", o_err[9]);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_err();
      test_back_to_back();
      test_mid_reset();
      test_copy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
